id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register directly downstream of the opcode control decoder in the 5-stage RV32I core.
- Latches decoded control signals, operands, immediate and register indices each cycle for the EX stage.
- Detects load-use hazards and drives the stall that gates the decoder's select_control_unit and holds PC/IF-ID.
- Supports bubble insertion, branch flush and external hold.

Parameters:
XLEN, 32, datapath width of pc/operands/immediate
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
id_reg_write  input  1  decoder RegWrite
id_alu_op  input  2  decoder ALUOp
id_mem_read  input  1  decoder MemRead
id_mem_write  input  1  decoder MemWrite
id_mem_to_reg  input  1  decoder MemtoReg (may be z)
id_is_branch  input  1  decoder is_Branch
id_alu_src  input  2  decoder ALUSrc (may be z)
id_pc  input  XLEN  instruction PC
id_rs1_data, id_rs2_data  input  XLEN  register file reads
id_imm  input  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register indices
id_funct  input  4  {funct7[5], funct3}
hold  input  1  downstream memory stall: freeze EX contents
flush  input  1  branch taken in EX: kill instruction entering EX
hazard_stall  output  1  load-use stall; drives select_control_unit low, holds PC and IF/ID
ex_valid  output  1  EX slot holds a real instruction
ex_* outputs  output  same widths  registered copies of every id_* input above

Behaviour:
- Reset (async, immediate): all ex_* outputs 0, ex_valid 0. hazard_stall evaluates to 0 because ex_mem_read=0.
- Sanitisation: any id control bit that is not a strict 1 (0, z, x) is captured as 0. No z/x ever reaches ex_* outputs.
- hazard_stall is combinational: asserted when ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - Asserted regardless of hold.
  - Does not check whether the ID instruction actually uses rs2. This conservative over-stall is accepted.
- Per-edge update priority:
  1. flush: all control outputs 0, ex_valid 0; data fields don't-care, implemented as 0.
  2. hold: all ex_* unchanged, including ex_valid.
  3. hazard_stall: bubble, same clearing as flush. Decoder inputs are ignored because select_control_unit is low.
  4. otherwise: load sanitised id_* into ex_*, ex_valid 1.
- Latency: 1 cycle, ID to EX.
- A load-use bubble lasts exactly one cycle. After it, ex_mem_read=0 and the stall drops.
- flush and hazard_stall in the same cycle: flush wins, bubble result identical.
- flush with hold: flush wins.
- Reset mid-stall: outputs clear immediately and hazard_stall deasserts in the same cycle.
- rd=x0 never causes a stall.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_bubbles [31:0] and perf_flushes [31:0].
  - perf_bubbles increments on each hazard bubble edge (hazard_stall & !flush & !hold).
  - perf_flushes increments on each flush edge.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants: R=0110011, LOAD=0000011, STORE=0100011, OPIMM=0010011, BRANCH=1100011
  - ALUOp encodings 00/01/10/11 and ALUSrc encodings
  - XLEN/REG_ADDR_W defaults
  - struct ctrl_t bundling the seven control fields, which are passed as one bundle
- One sub-module, load_use_detect: the combinational hazard compare, instantiated once and reused by the future forwarding unit.
- The register itself stays flat.

Test Plan:
- Reset then R-type: rst high then low, then load id_reg_write=1, id_alu_op=10, id_rd=5. Expected next edge: ex_reg_write=1, ex_alu_op=10, ex_rd=5, ex_valid=1.
- Load-use: EX holds lw x6 (mem_read=1, rd=6); ID presents id_rs2=6. Expected: hazard_stall=1 this cycle; next edge bubble (ex_valid=0, ex_mem_read=0); hazard_stall=0 the following cycle.
- x0 load: EX lw with rd=0, ID id_rs1=0. Expected: hazard_stall=0; normal load.
- Sanitisation: id_mem_to_reg=z, id_alu_src=zz on an sw (mem_write=1). Expected: ex_mem_to_reg=0, ex_alu_src=00, ex_mem_write=1, no x/z on any output.
- Priority: flush=1 and hold=1 simultaneously with a valid ID instruction. Expected: ex_valid=0, all controls 0. With hold=1 alone for 3 cycles: ex_* unchanged.
- Async reset mid-stall: assert rst between edges while hazard_stall=1. Expected: outputs 0 and hazard_stall=0 without waiting for clk. With ID_EX_PERF_CNT_EN, counters read 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, control bundle type and input sanitisation helpers
package riscv_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int REG_ADDR_W_DEF = 5;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

    localparam logic [1:0] ALUSRC_REG  = 2'b00;
    localparam logic [1:0] ALUSRC_IMM  = 2'b01;
    localparam logic [1:0] ALUSRC_PC   = 2'b10;
    localparam logic [1:0] ALUSRC_RSVD = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] alu_op;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       is_branch;
        logic [1:0] alu_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // The decoder can float its outputs while select_control_unit is low; only a clean 1 counts.
    function automatic logic strict_one(input logic b);
        return (b === 1'b1);
    endfunction

    function automatic ctrl_t sanitize_ctrl(input ctrl_t c);
        ctrl_t s;
        s.reg_write  = strict_one(c.reg_write);
        s.alu_op     = {strict_one(c.alu_op[1]), strict_one(c.alu_op[0])};
        s.mem_read   = strict_one(c.mem_read);
        s.mem_write  = strict_one(c.mem_write);
        s.mem_to_reg = strict_one(c.mem_to_reg);
        s.is_branch  = strict_one(c.is_branch);
        s.alu_src    = {strict_one(c.alu_src[1]), strict_one(c.alu_src[0])};
        return s;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard compare between EX load and ID sources
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    output logic                  stall
);

    // rs2 is compared even for instructions that do not read it; the extra stall is harmless.
    assign stall = ex_valid && ex_mem_read && (ex_rd != '0)
                   && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with load-use stall; ID_EX_PERF_CNT_EN adds bubble/flush counters
module id_ex_reg
    import riscv_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_reg_write,
    input  logic [1:0]            id_alu_op,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  id_is_branch,
    input  logic [1:0]            id_alu_src,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [XLEN-1:0]       id_rs1_data,
    input  logic [XLEN-1:0]       id_rs2_data,
    input  logic [XLEN-1:0]       id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic [3:0]            id_funct,
    input  logic                  hold,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  ex_valid,
    output logic                  ex_reg_write,
    output logic [1:0]            ex_alu_op,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg,
    output logic                  ex_is_branch,
    output logic [1:0]            ex_alu_src,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_rs1_data,
    output logic [XLEN-1:0]       ex_rs2_data,
    output logic [XLEN-1:0]       ex_imm,
    output logic [REG_ADDR_W-1:0] ex_rs1,
    output logic [REG_ADDR_W-1:0] ex_rs2,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [3:0]            ex_funct
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]           perf_bubbles,
    output logic [31:0]           perf_flushes
`endif
);

    ctrl_t                  ctrl_q, ctrl_d, id_ctrl;
    logic                   valid_q, valid_d;
    logic [XLEN-1:0]        pc_q, pc_d, rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]        rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [REG_ADDR_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [3:0]             funct_q, funct_d;
    logic                   kill;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
        .ex_valid    (valid_q),
        .ex_mem_read (ctrl_q.mem_read),
        .ex_rd       (rd_q),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .stall       (hazard_stall)
    );

    assign id_ctrl = sanitize_ctrl('{id_reg_write, id_alu_op, id_mem_read, id_mem_write,
                                     id_mem_to_reg, id_is_branch, id_alu_src});

    // flush beats hold; a load-use bubble only happens when not held.
    assign kill = flush || (!hold && hazard_stall);

    always_comb begin
        ctrl_d     = ctrl_q;
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct_d    = funct_q;
        if (kill) begin
            ctrl_d     = CTRL_NOP;
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_d      = '0;
            rs2_d      = '0;
            rd_d       = '0;
            funct_d    = '0;
        end else if (!hold) begin
            ctrl_d     = id_ctrl;
            valid_d    = 1'b1;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_d      = id_rs1;
            rs2_d      = id_rs2;
            rd_d       = id_rd;
            funct_d    = id_funct;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= CTRL_NOP;
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct_q    <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct_q    <= funct_d;
        end
    end

    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_alu_op     = ctrl_q.alu_op;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign ex_is_branch  = ctrl_q.is_branch;
    assign ex_alu_src    = ctrl_q.alu_src;
    assign ex_pc         = pc_q;
    assign ex_rs1_data   = rs1_data_q;
    assign ex_rs2_data   = rs2_data_q;
    assign ex_imm        = imm_q;
    assign ex_rs1        = rs1_q;
    assign ex_rs2        = rs2_q;
    assign ex_rd         = rd_q;
    assign ex_funct      = funct_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d, perf_flushes_q, perf_flushes_d;

    always_comb begin
        perf_bubbles_d = perf_bubbles_q;
        perf_flushes_d = perf_flushes_q;
        if (hazard_stall && !flush && !hold && (perf_bubbles_q != 32'hFFFF_FFFF))
            perf_bubbles_d = perf_bubbles_q + 32'd1;
        if (flush && (perf_flushes_q != 32'hFFFF_FFFF))
            perf_flushes_d = perf_flushes_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_bubbles_q <= '0;
            perf_flushes_q <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_flushes_q <= perf_flushes_d;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_flushes = perf_flushes_q;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// tb/tb_id_ex_reg.sv - directed self-checking bench for id_ex_reg
module tb_id_ex_reg;

    logic        clk, rst;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_is_branch;
    logic [1:0]  id_alu_op, id_alu_src;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        hold, flush;
    logic        hazard_stall, ex_valid;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_is_branch;
    logic [1:0]  ex_alu_op, ex_alu_src;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_funct;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_flushes;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_reg dut (
        .clk(clk), .rst(rst),
        .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg), .id_is_branch(id_is_branch),
        .id_alu_src(id_alu_src), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_funct(id_funct), .hold(hold), .flush(flush),
        .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_alu_op(ex_alu_op), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_is_branch(ex_is_branch), .ex_alu_src(ex_alu_src),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubbles(perf_bubbles), .perf_flushes(perf_flushes)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_id(input logic rw, input logic [1:0] aop, input logic mr, input logic mw,
                            input logic mtr, input logic br, input logic [1:0] asrc,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        id_reg_write = rw;  id_alu_op = aop;   id_mem_read = mr;  id_mem_write = mw;
        id_mem_to_reg = mtr; id_is_branch = br; id_alu_src = asrc;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_pc = 32'h1000 + {27'd0, rd}; id_rs1_data = 32'hA5A5_0000 + {27'd0, rs1};
        id_rs2_data = 32'h5A5A_0000 + {27'd0, rs2}; id_imm = 32'hFFFF_FFF0; id_funct = 4'b1000;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        drive_id(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
        #3;
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_alu_op, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             ex_is_branch, ex_alu_src, ex_rd, ex_pc} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got valid=%b rd=%0d pc=%h want all 0", ex_valid, ex_rd, ex_pc);
        end
        n_checks++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", hazard_stall); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        drive_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 5'd2, 5'd5);
        step();
        n_checks++;
        if ({ex_reg_write, ex_alu_op, ex_rd, ex_valid} !== {1'b1, 2'b10, 5'd5, 1'b1}) begin
            n_fail++; $display("FAIL rtype_load: got rw=%b aop=%b rd=%0d v=%b want 1 10 5 1", ex_reg_write, ex_alu_op, ex_rd, ex_valid);
        end
        n_checks++;
        if ({ex_pc, ex_rs1_data, ex_rs2_data, ex_funct} !== {32'h1005, 32'hA5A5_0001, 32'h5A5A_0002, 4'b1000}) begin
            n_fail++; $display("FAIL rtype_data: got pc=%h rs1d=%h rs2d=%h want 1005 a5a50001 5a5a0002", ex_pc, ex_rs1_data, ex_rs2_data);
        end
    endtask

    task automatic test_load_use();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd6);
        step();
        drive_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 5'd6, 5'd7);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_on: got %b want 1", hazard_stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write} !== 3'b000) begin
            n_fail++; $display("FAIL lu_bubble: got v=%b mr=%b rw=%b want 000", ex_valid, ex_mem_read, ex_reg_write);
        end
        n_checks++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_off: got %b want 0", hazard_stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_rd, ex_rs2} !== {1'b1, 5'd7, 5'd6}) begin
            n_fail++; $display("FAIL lu_resume: got v=%b rd=%0d rs2=%0d want 1 7 6", ex_valid, ex_rd, ex_rs2);
        end
    endtask

    task automatic test_x0_load();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd3, 5'd0, 5'd0);
        step();
        drive_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd8);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL x0_no_stall: got %b want 0", hazard_stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_rd, ex_mem_read} !== {1'b1, 5'd8, 1'b0}) begin
            n_fail++; $display("FAIL x0_next_load: got v=%b rd=%0d mr=%b want 1 8 0", ex_valid, ex_rd, ex_mem_read);
        end
    endtask

    task automatic test_sanitise();
        drive_id(1'b0, 2'b00, 1'b0, 1'b1, 1'bz, 1'b0, 2'bzz, 5'd3, 5'd4, 5'd0);
        step();
        n_checks++;
        if ({ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_valid} !== {1'b1, 1'b0, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL san_fields: got mw=%b mtr=%b asrc=%b v=%b want 1 0 00 1", ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_valid);
        end
        n_checks++;
        if ($isunknown({hazard_stall, ex_valid, ex_reg_write, ex_alu_op, ex_mem_read, ex_mem_write,
                        ex_mem_to_reg, ex_is_branch, ex_alu_src, ex_pc, ex_rs1_data, ex_rs2_data,
                        ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct}) !== 1'b0) begin
            n_fail++; $display("FAIL san_no_xz: got unknown bits on outputs want none");
        end
    endtask

    task automatic test_priority();
        drive_id(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 5'd1, 5'd2, 5'd9);
        flush = 1'b1; hold = 1'b1;
        step();
        flush = 1'b0; hold = 1'b0;
        n_checks++;
        if ({ex_valid, ex_reg_write, ex_alu_op, ex_mem_read, ex_mem_write, ex_mem_to_reg,
             ex_is_branch, ex_alu_src} !== 10'd0) begin
            n_fail++; $display("FAIL prio_flush_hold: got v=%b rw=%b aop=%b br=%b want all 0", ex_valid, ex_reg_write, ex_alu_op, ex_is_branch);
        end
        step();
        hold = 1'b1;
        drive_id(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 5'd4, 5'd5, 5'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({ex_valid, ex_reg_write, ex_alu_op, ex_is_branch, ex_mem_write, ex_rd, ex_pc} !==
                {1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 5'd9, 32'h1009}) begin
                n_fail++; $display("FAIL hold_cycle%0d: got v=%b rw=%b aop=%b rd=%0d pc=%h want 1 1 11 9 1009", i, ex_valid, ex_reg_write, ex_alu_op, ex_rd, ex_pc);
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_stall_combos();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd11);
        step();
        drive_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd11, 5'd3, 5'd12);
        hold = 1'b1;
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL hold_stall_on: got %b want 1", hazard_stall); end
        step();
        n_checks++;
        if ({ex_valid, ex_mem_read, ex_rd, hazard_stall} !== {1'b1, 1'b1, 5'd11, 1'b1}) begin
            n_fail++; $display("FAIL hold_over_stall: got v=%b mr=%b rd=%0d st=%b want 1 1 11 1", ex_valid, ex_mem_read, ex_rd, hazard_stall);
        end
        hold = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++;
        if ({ex_valid, ex_mem_read, ex_reg_write, hazard_stall} !== 4'b0000) begin
            n_fail++; $display("FAIL flush_over_stall: got v=%b mr=%b rw=%b st=%b want 0000", ex_valid, ex_mem_read, ex_reg_write, hazard_stall);
        end
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if ({perf_bubbles, perf_flushes} !== {32'd1, 32'd2}) begin
            n_fail++; $display("FAIL perf_counts: got bub=%0d fl=%0d want 1 2", perf_bubbles, perf_flushes);
        end
`endif
    endtask

    task automatic test_async_reset();
        drive_id(1'b1, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 5'd2, 5'd0, 5'd13);
        step();
        drive_id(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 5'd1, 5'd13, 5'd14);
        #1;
        n_checks++;
        if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL ar_stall_before: got %b want 1", hazard_stall); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({hazard_stall, ex_valid, ex_mem_read, ex_reg_write, ex_rd, ex_pc} !== '0) begin
            n_fail++; $display("FAIL ar_clear: got st=%b v=%b mr=%b rd=%0d pc=%h want all 0", hazard_stall, ex_valid, ex_mem_read, ex_rd, ex_pc);
        end
`ifdef ID_EX_PERF_CNT_EN
        n_checks++;
        if ({perf_bubbles, perf_flushes} !== 64'd0) begin
            n_fail++; $display("FAIL ar_perf: got bub=%0d fl=%0d want 0 0", perf_bubbles, perf_flushes);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if ({ex_valid, ex_rd} !== {1'b1, 5'd14}) begin
            n_fail++; $display("FAIL ar_recover: got v=%b rd=%0d want 1 14", ex_valid, ex_rd);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_load_use();
        test_x0_load();
        test_sanitise();
        test_priority();
        test_stall_combos();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
